// File: rtl/rv32_pkg.sv
`default_nettype none
// ==========================================================================
// rv32_pkg : shared hazard-unit types and constants.  Rev 1.0
// ==========================================================================
package rv32_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

  localparam logic [1:0] DCTRL_LOAD = 2'b11;
  localparam logic [4:0] REG_X0     = 5'd0;
endpackage
`default_nettype wire

// File: rtl/rv32_hazard_unit_if.sv
`default_nettype none
// ==========================================================================
// rv32_hazard_unit_if : stage status in, pipeline control out.  Rev 1.0
// ==========================================================================
interface rv32_hazard_unit_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [4:0]  ex_rd_i;
  logic        ex_rf_wr_i;
  logic [1:0]  ex_data_ctrl_i;
  logic        ex_redirect_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_stall_o;
  logic        id_ex_flush_o;
  logic        pipe_busy_o;
  logic        mem_timeout_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [31:0] busy_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
           ex_rf_wr_i, ex_data_ctrl_i, ex_redirect_i, mem_req_i, mem_ack_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_flush_o, pipe_busy_o, mem_timeout_o,
           stall_cnt_o, flush_cnt_o, busy_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
           ex_rf_wr_i, ex_data_ctrl_i, ex_redirect_i, mem_req_i, mem_ack_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_flush_o, pipe_busy_o, mem_timeout_o,
           stall_cnt_o, flush_cnt_o, busy_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/rv32_perf_counter.sv
`default_nettype none
// ==========================================================================
// rv32_perf_counter : 32-bit wrapping event counter.  Rev 1.0
// ==========================================================================
module rv32_perf_counter (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        inc_i,
  output logic [31:0]      count_o
);
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= 32'd0;
    else if (inc_i) cnt_q <= cnt_q + 32'd1;
  end

  assign count_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/rv32_hazard_unit.sv
`default_nettype none
// ==========================================================================
// rv32_hazard_unit : load-use stall, redirect flush, memory-wait freeze.  Rev 1.0
// ==========================================================================
module rv32_hazard_unit
  import rv32_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  wire logic         clk,
  input  wire logic         rst,
  rv32_hazard_unit_if.slave bus
);
  localparam int RW    = $clog2(FLUSH_CYCLES + 1);
  localparam int TW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RW-1:0] c_reload = RW'(FLUSH_CYCLES - 1);
  localparam logic [RW-1:0] c_rem_one = RW'(1);
  localparam logic [TW-1:0] c_tmo_max = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0] c_tmo_one = TW'(1);

  hazard_state_t state_q, state_d;
  logic [RW-1:0] remain_q, remain_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;

  logic w_load_use, w_wait_start, w_release;
  logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall, w_id_ex_flush, w_busy;

  assign w_load_use = (bus.ex_data_ctrl_i == DCTRL_LOAD) & bus.ex_rf_wr_i &
                      (bus.ex_rd_i != REG_X0) &
                      ((bus.id_rs1_used_i & (bus.id_rs1_i == bus.ex_rd_i)) |
                       (bus.id_rs2_used_i & (bus.id_rs2_i == bus.ex_rd_i)));
  assign w_wait_start = bus.mem_req_i & ~bus.mem_ack_i;
  assign w_release    = bus.mem_ack_i | (tmo_q == c_tmo_max);

  always_comb begin
    state_d       = state_q;
    remain_d      = remain_q;
    tmo_d         = tmo_q;
    timeout_d     = timeout_q;
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_stall = 1'b0;
    w_id_ex_flush = 1'b0;
    w_busy        = 1'b0;

    if (state_q == MEM_WAIT && !w_release) begin
      w_busy = 1'b1;
      if (tmo_q != c_tmo_max) tmo_d = tmo_q + c_tmo_one;
    end else begin
      // On release the pipeline moves this cycle, so a held redirect is serviced now.
      if (state_q == MEM_WAIT) begin
        state_d = RUN;
        if (!bus.mem_ack_i) timeout_d = 1'b1;
      end
      if (state_q != MEM_WAIT && w_wait_start) begin
        w_busy  = 1'b1;
        state_d = MEM_WAIT;
        tmo_d   = c_tmo_one;
      end else if (bus.ex_redirect_i) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d  = FLUSH;
          remain_d = c_reload;
        end else begin
          state_d = RUN;
        end
      end else if (state_q == FLUSH) begin
        w_if_id_flush = 1'b1;
        remain_d      = remain_q - c_rem_one;
        if (remain_q == c_rem_one) state_d = RUN;
      end else if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      remain_q  <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.pc_stall_o    = w_pc_stall    & ~rst;
  assign bus.if_id_stall_o = w_if_id_stall & ~rst;
  assign bus.if_id_flush_o = w_if_id_flush & ~rst;
  assign bus.id_ex_stall_o = w_id_ex_stall & ~rst;
  assign bus.id_ex_flush_o = w_id_ex_flush & ~rst;
  assign bus.pipe_busy_o   = w_busy        & ~rst;
  assign bus.mem_timeout_o = timeout_q;

  rv32_perf_counter u_stall_cnt (
    .clk(clk), .rst(rst), .inc_i(bus.id_ex_stall_o), .count_o(bus.stall_cnt_o)
  );
  rv32_perf_counter u_flush_cnt (
    .clk(clk), .rst(rst), .inc_i(bus.if_id_flush_o), .count_o(bus.flush_cnt_o)
  );
  rv32_perf_counter u_busy_cnt (
    .clk(clk), .rst(rst), .inc_i(bus.pipe_busy_o), .count_o(bus.busy_cnt_o)
  );
endmodule
`default_nettype wire

// File: tb/tb_rv32_hazard_unit.sv
`default_nettype none
// ==========================================================================
// tb_rv32_hazard_unit : directed checks of stall, flush and memory-wait control.
// ==========================================================================
module tb_rv32_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  rv32_hazard_unit_if hz ();

  rv32_hazard_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hz)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, pipe_busy}
  logic [5:0] ctrl;
  assign ctrl = {hz.pc_stall_o, hz.if_id_stall_o, hz.if_id_flush_o,
                 hz.id_ex_stall_o, hz.id_ex_flush_o, hz.pipe_busy_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs1_i = 5'd0;       hz.id_rs2_i = 5'd0;
    hz.id_rs1_used_i = 1'b0;  hz.id_rs2_used_i = 1'b0;
    hz.ex_rd_i = 5'd0;        hz.ex_rf_wr_i = 1'b0;
    hz.ex_data_ctrl_i = 2'b00; hz.ex_redirect_i = 1'b0;
    hz.mem_req_i = 1'b0;      hz.mem_ack_i = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hz.ex_data_ctrl_i = 2'b11; hz.ex_rf_wr_i = 1'b1; hz.ex_rd_i = rd;
    hz.id_rs2_i = rd;          hz.id_rs2_used_i = 1'b1;
  endtask

  initial begin
    // Reset held with every input driven high
    hz.id_rs1_i = 5'd5; hz.id_rs2_i = 5'd5; hz.id_rs1_used_i = 1'b1; hz.id_rs2_used_i = 1'b1;
    hz.ex_rd_i = 5'd5; hz.ex_rf_wr_i = 1'b1; hz.ex_data_ctrl_i = 2'b11;
    hz.ex_redirect_i = 1'b1; hz.mem_req_i = 1'b1; hz.mem_ack_i = 1'b1;
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    hz.mem_ack_i = 1'b0;
    tick(); tick();
    chk("rst_ctrl_noack", 32'(ctrl), 32'h0);
    chk("rst_timeout", 32'(hz.mem_timeout_o), 32'h0);
    chk("rst_stall_cnt", hz.stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", hz.flush_cnt_o, 32'd0);
    chk("rst_busy_cnt", hz.busy_cnt_o, 32'd0);
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_ctrl", 32'(ctrl), 32'h0);
    chk("post_rst_cnt", hz.stall_cnt_o | hz.flush_cnt_o | hz.busy_cnt_o, 32'd0);

    // Load-use on rs2 with rd=5
    set_load_use(5'd5);
    #1;
    chk("lu_ctrl", 32'(ctrl), 32'h34);
    tick();
    hz.ex_data_ctrl_i = 2'b00;
    #1;
    chk("lu_bubble_ctrl", 32'(ctrl), 32'h0);
    chk("lu_stall_cnt", hz.stall_cnt_o, 32'd1);

    // x0 is never a hazard
    set_load_use(5'd0);
    #1;
    chk("lu_x0_ctrl", 32'(ctrl), 32'h0);
    tick();
    idle_inputs();
    chk("lu_x0_stall_cnt", hz.stall_cnt_o, 32'd1);

    // Redirect pulse: two flush cycles
    hz.ex_redirect_i = 1'b1;
    #1;
    chk("redir_c0", 32'(ctrl), 32'h0A);
    tick();
    hz.ex_redirect_i = 1'b0;
    #1;
    chk("redir_c1", 32'(ctrl), 32'h08);
    tick();
    chk("redir_c2", 32'(ctrl), 32'h0);
    chk("redir_flush_cnt", hz.flush_cnt_o, 32'd2);

    // Redirect with coincident load-use: flush wins, stall suppressed in FLUSH too
    set_load_use(5'd7);
    hz.ex_redirect_i = 1'b1;
    #1;
    chk("redir_lu_c0", 32'(ctrl), 32'h0A);
    tick();
    hz.ex_redirect_i = 1'b0;
    #1;
    chk("redir_lu_c1", 32'(ctrl), 32'h08);
    tick();
    idle_inputs();
    #1;
    chk("redir_lu_c2", 32'(ctrl), 32'h0);
    chk("redir_lu_stall_cnt", hz.stall_cnt_o, 32'd1);
    chk("redir_lu_flush_cnt", hz.flush_cnt_o, 32'd4);

    // Memory access acknowledged three cycles after request
    hz.mem_req_i = 1'b1;
    #1;
    chk("mem_c0", 32'(ctrl), 32'h01);
    tick();
    chk("mem_c1", 32'(ctrl), 32'h01);
    tick();
    chk("mem_c2", 32'(ctrl), 32'h01);
    tick();
    hz.mem_ack_i = 1'b1;
    #1;
    chk("mem_ack_c3", 32'(ctrl), 32'h0);
    tick();
    idle_inputs();
    chk("mem_busy_cnt", hz.busy_cnt_o, 32'd3);

    // Request and acknowledge in the same cycle
    hz.mem_req_i = 1'b1; hz.mem_ack_i = 1'b1;
    #1;
    chk("mem_same_cycle", 32'(ctrl), 32'h0);
    tick();
    idle_inputs();
    #1;
    chk("mem_same_after", 32'(ctrl), 32'h0);
    chk("mem_same_busy_cnt", hz.busy_cnt_o, 32'd3);

    // No acknowledge: released after four busy cycles with sticky timeout
    hz.mem_req_i = 1'b1;
    #1;
    chk("tmo_c0", 32'(ctrl), 32'h01);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("tmo_c%0d", i), 32'(ctrl), 32'h01);
    end
    tick();
    hz.mem_req_i = 1'b0;
    #1;
    chk("tmo_release", 32'(ctrl), 32'h0);
    tick();
    chk("tmo_flag", 32'(hz.mem_timeout_o), 32'h1);
    chk("tmo_busy_cnt", hz.busy_cnt_o, 32'd7);
    tick(); tick();
    chk("tmo_sticky", 32'(hz.mem_timeout_o), 32'h1);
    chk("tmo_idle_ctrl", 32'(ctrl), 32'h0);

    // Reset in the middle of a memory wait
    hz.mem_req_i = 1'b1;
    tick();
    chk("midwait_busy", 32'(ctrl), 32'h01);
    rst = 1'b1;
    #1;
    chk("midwait_rst_ctrl", 32'(ctrl), 32'h0);
    chk("midwait_rst_tmo", 32'(hz.mem_timeout_o), 32'h0);
    chk("midwait_rst_busy_cnt", hz.busy_cnt_o, 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    set_load_use(5'd9);
    #1;
    chk("midwait_run_state", 32'(ctrl), 32'h34);
    chk("midwait_tmo_clear", 32'(hz.mem_timeout_o), 32'h0);
    tick();
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
